// File: rtl/axi_pwm_4ch_s_axi_if.sv
// ============================================================================
// Module  : axi_pwm_4ch_s_axi_if
// Brief   : AXI4-Lite slave bus bundle for the 4-channel PWM block.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface axi_pwm_4ch_s_axi_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]     awaddr;
  logic [2:0]                        awprot;
  logic                              awvalid;
  logic                              awready;
  logic [C_S_AXI_DATA_WIDTH-1:0]     wdata;
  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] wstrb;
  logic                              wvalid;
  logic                              wready;
  logic [1:0]                        bresp;
  logic                              bvalid;
  logic                              bready;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     araddr;
  logic [2:0]                        arprot;
  logic                              arvalid;
  logic                              arready;
  logic [C_S_AXI_DATA_WIDTH-1:0]     rdata;
  logic [1:0]                        rresp;
  logic                              rvalid;
  logic                              rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

`default_nettype wire

// File: rtl/axi_pwm_4ch_s_axi.sv
// ============================================================================
// Module  : axi_pwm_4ch_s_axi
// Brief   : AXI4-Lite register slave driving four PWM channels off a shared
//           period counter, with per-channel shadowed duty registers.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi_pwm_4ch_s_axi #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  wire logic             s00_axi_aclk,
  input  wire logic             s00_axi_aresetn,
  axi_pwm_4ch_s_axi_if.slave    s00_axi,
  output logic [3:0]            pwm_out
);

  localparam int                          c_DW          = C_S_AXI_DATA_WIDTH;
  localparam logic [31:0]                 c_ID          = 32'h5057_4D34;
  localparam logic [2:0]                  c_ADDR_PERIOD = 3'd4;
  localparam logic [2:0]                  c_ADDR_CTRL   = 3'd5;
  localparam logic [2:0]                  c_ADDR_COUNT  = 3'd6;
  localparam logic [2:0]                  c_ADDR_ID     = 3'd7;

  logic            r_awready;
  logic            r_bvalid;
  logic            r_arready;
  logic            r_rvalid;
  logic [c_DW-1:0] r_rdata;
  logic [c_DW-1:0] r_duty   [4];
  logic [c_DW-1:0] r_shadow [4];
  logic [c_DW-1:0] r_period;
  logic [3:0]      r_ctrl;
  logic [31:0]     r_cnt;
  logic [3:0]      r_pwm;

  logic            w_wr_en;
  logic            w_rd_en;
  logic [c_DW-1:0] w_wr_old;
  logic [c_DW-1:0] w_wr_new;
  logic [c_DW-1:0] w_rd_mux;
  logic            w_period_nz;
  logic            w_wrap;
  logic            w_unused;

  function automatic logic [c_DW-1:0] f_merge(input logic [c_DW-1:0]     old_val,
                                              input logic [c_DW-1:0]     new_val,
                                              input logic [c_DW/8-1:0]   strb);
    f_merge = old_val;
    for (int b = 0; b < c_DW / 8; b++) begin
      if (strb[b]) f_merge[8*b +: 8] = new_val[8*b +: 8];
    end
  endfunction

  // Handshake completes on the edge that ends the one-cycle ready pulse.
  assign w_wr_en = r_awready && s00_axi.awvalid && s00_axi.wvalid;
  assign w_rd_en = r_arready && s00_axi.arvalid;

  always_comb begin
    w_wr_old = '0;
    case (s00_axi.awaddr[4:2])
      3'd0, 3'd1, 3'd2, 3'd3: w_wr_old = r_duty[s00_axi.awaddr[3:2]];
      c_ADDR_PERIOD:          w_wr_old = r_period;
      c_ADDR_CTRL:            w_wr_old = {{(c_DW-4){1'b0}}, r_ctrl};
      default:                w_wr_old = '0;
    endcase
  end

  assign w_wr_new = f_merge(w_wr_old, s00_axi.wdata, s00_axi.wstrb);

  always_comb begin
    w_rd_mux = '0;
    case (s00_axi.araddr[4:2])
      3'd0, 3'd1, 3'd2, 3'd3: w_rd_mux = r_duty[s00_axi.araddr[3:2]];
      c_ADDR_PERIOD:          w_rd_mux = r_period;
      c_ADDR_CTRL:            w_rd_mux = {{(c_DW-4){1'b0}}, r_ctrl};
      c_ADDR_COUNT:           w_rd_mux = r_cnt;
      c_ADDR_ID:              w_rd_mux = c_ID;
      default:                w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_period  <= '0;
      r_ctrl    <= '0;
      for (int i = 0; i < 4; i++) r_duty[i] <= '0;
    end else begin
      r_awready <= !r_awready && s00_axi.awvalid && s00_axi.wvalid && !r_bvalid;
      if (w_wr_en)              r_bvalid <= 1'b1;
      else if (s00_axi.bready)  r_bvalid <= 1'b0;
      if (w_wr_en) begin
        case (s00_axi.awaddr[4:2])
          3'd0, 3'd1, 3'd2, 3'd3: r_duty[s00_axi.awaddr[3:2]] <= w_wr_new;
          c_ADDR_PERIOD:          r_period <= w_wr_new;
          c_ADDR_CTRL:            r_ctrl   <= w_wr_new[3:0];
          default:                ;
        endcase
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= !r_arready && s00_axi.arvalid && !r_rvalid;
      if (w_rd_en) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_mux;
      end else if (s00_axi.rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign w_period_nz = |r_period;
  // A PERIOD shrunk below the running count is treated as an immediate wrap.
  assign w_wrap      = w_period_nz && (r_cnt >= r_period - 32'd1);

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_cnt <= '0;
      r_pwm <= '0;
      for (int i = 0; i < 4; i++) r_shadow[i] <= '0;
    end else begin
      if (!w_period_nz || w_wrap) r_cnt <= '0;
      else                        r_cnt <= r_cnt + 32'd1;
      for (int i = 0; i < 4; i++) begin
        // Shadows follow DUTY while idle so the first period starts with it.
        if (!w_period_nz || w_wrap) r_shadow[i] <= r_duty[i];
        r_pwm[i] <= r_ctrl[i] && w_period_nz && (r_cnt < r_shadow[i]);
      end
    end
  end

  assign s00_axi.awready = r_awready;
  assign s00_axi.wready  = r_awready;
  assign s00_axi.bvalid  = r_bvalid;
  assign s00_axi.bresp   = 2'b00;
  assign s00_axi.arready = r_arready;
  assign s00_axi.rvalid  = r_rvalid;
  assign s00_axi.rdata   = r_rdata;
  assign s00_axi.rresp   = 2'b00;
  assign pwm_out         = r_pwm;

  assign w_unused = ^{s00_axi.awprot, s00_axi.arprot,
                      s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_axi_pwm_4ch_s_axi.sv
// ============================================================================
// Module  : tb_axi_pwm_4ch_s_axi
// Brief   : Directed and randomized self-checking bench for axi_pwm_4ch_s_axi.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_axi_pwm_4ch_s_axi;

  logic       tb_ACLK = 1'b0;
  logic       tb_ARESETN;
  logic [3:0] pwm_out;

  axi_pwm_4ch_s_axi_if bus ();

  axi_pwm_4ch_s_axi dut (
    .s00_axi_aclk    (tb_ACLK),
    .s00_axi_aresetn (tb_ARESETN),
    .s00_axi         (bus.slave),
    .pwm_out         (pwm_out)
  );

  always #5 tb_ACLK = ~tb_ACLK;

  int n_checks = 0;
  int n_pass   = 0;
  int hi_cnt [4];
  int runs [$];
  int run_len = 0;

  // High-run lengths of channel 0, sampled mid-cycle.
  initial forever begin
    @(negedge tb_ACLK);
    if (pwm_out[0]) run_len++;
    else if (run_len != 0) begin
      runs.push_back(run_len);
      run_len = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge tb_ACLK);
      #1;
    end
  endtask

  task automatic wr_req(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    logic ok;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = bus.awready && bus.wready;
    end
    chk("aw_w_ready", {31'd0, ok}, 32'd1);
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
  endtask

  task automatic wr_rsp();
    logic ok;
    ok = bus.bvalid;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = bus.bvalid;
    end
    chk("bvalid_seen", {31'd0, ok}, 32'd1);
    chk("bresp", {30'd0, bus.bresp}, 32'd0);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    wr_req(a, d, s);
    wr_rsp();
  endtask

  task automatic rd_req(input logic [4:0] a);
    logic ok;
    bus.araddr = a; bus.arvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = bus.arready;
    end
    chk("arready", {31'd0, ok}, 32'd1);
    tick();
    bus.arvalid = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    logic ok;
    rd_req(a);
    ok = bus.rvalid;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = bus.rvalid;
    end
    chk("rvalid_seen", {31'd0, ok}, 32'd1);
    chk("rresp", {30'd0, bus.rresp}, 32'd0);
    d = bus.rdata;
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
  endtask

  task automatic rd_chk(input logic [4:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic measure(input int p);
    for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
    repeat (p) begin
      tick();
      for (int i = 0; i < 4; i++) hi_cnt[i] += int'(pwm_out[i]);
    end
  endtask

  initial begin
    logic [31:0] d0;
    logic        held, stable, acc, bad, ok, prev;
    int          p, duty [4];
    logic [3:0]  ctl;
    int          r0, r1;

    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata  = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    tb_ARESETN = 1'b0;
    tick(3);
    chk("rst_ctrl_outs", {26'd0, bus.awready, bus.wready, bus.bvalid, bus.arready,
                          bus.rvalid, 1'b0}, 32'd0);
    chk("rst_pwm", {28'd0, pwm_out}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    tb_ARESETN = 1'b1;
    tick();
    rd_chk(5'h10, 32'd0, "rst_period");
    rd_chk(5'h18, 32'd0, "rst_count");

    // Duty register write/readback
    wr(5'h00, 32'h0101_FFFF); wr(5'h04, 32'hABCD_0001);
    wr(5'h08, 32'hDEAD_0011); wr(5'h0C, 32'hBEEF_0011);
    rd_chk(5'h00, 32'h0101_FFFF, "duty0_rb");
    rd_chk(5'h04, 32'hABCD_0001, "duty1_rb");
    rd_chk(5'h08, 32'hDEAD_0011, "duty2_rb");
    rd_chk(5'h0C, 32'hBEEF_0011, "duty3_rb");

    // Byte strobes, read-only registers, CTRL width
    wr(5'h00, 32'h0);
    wr(5'h00, 32'hFFFF_FFFF, 4'b0101);
    rd_chk(5'h00, 32'h00FF_00FF, "strb_merge");
    wr(5'h00, 32'h1234_5678, 4'b0000);
    rd_chk(5'h00, 32'h00FF_00FF, "strb_zero");
    rd_chk(5'h1C, 32'h5057_4D34, "id");
    wr(5'h1C, 32'h0);
    rd_chk(5'h1C, 32'h5057_4D34, "id_ro");
    wr(5'h15, 32'hFFFF_FFFF);
    rd_chk(5'h14, 32'h0000_000F, "ctrl_width");
    wr(5'h18, 32'h0000_0055);
    rd_chk(5'h18, 32'd0, "count_ro");

    // Fixed duty pattern
    wr(5'h00, 32'd3); wr(5'h04, 32'd0); wr(5'h08, 32'd10); wr(5'h0C, 32'd20);
    wr(5'h14, 32'hF); wr(5'h10, 32'd10);
    tick(25);
    measure(10);
    chk("d3_ch0", hi_cnt[0], 32'd3);
    chk("d0_ch1", hi_cnt[1], 32'd0);
    chk("d10_ch2", hi_cnt[2], 32'd10);
    chk("d20_ch3", hi_cnt[3], 32'd10);

    // Disabling one channel does not disturb the others
    wr(5'h14, 32'hB);
    tick(2);
    chk("ctrl_clr_now", {31'd0, pwm_out[2]}, 32'd0);
    measure(10);
    chk("ctrl_clr_ch0", hi_cnt[0], 32'd3);
    chk("ctrl_clr_ch2", hi_cnt[2], 32'd0);
    chk("ctrl_clr_ch3", hi_cnt[3], 32'd10);
    wr(5'h14, 32'hF);

    // Duty change mid-period takes effect only from the next period
    prev = pwm_out[0]; ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      ok = !prev && pwm_out[0];
      prev = pwm_out[0];
    end
    chk("ch0_rise", {31'd0, ok}, 32'd1);
    runs.delete();
    wr(5'h00, 32'd7);
    tick(25);
    r0 = (runs.size() > 0) ? runs[0] : -1;
    r1 = (runs.size() > 1) ? runs[1] : -1;
    chk("run_current", r0, 32'd3);
    chk("run_next", r1, 32'd7);

    wr(5'h10, 32'd0);
    tick(2);
    chk("period0_pwm", {28'd0, pwm_out}, 32'd0);
    rd_chk(5'h18, 32'd0, "period0_count");

    // Randomized configurations against an arithmetic duty model
    for (int r = 0; r < 5; r++) begin
      p = $urandom_range(1, 24);
      for (int i = 0; i < 4; i++) duty[i] = $urandom_range(0, p + 4);
      ctl = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) wr(5'(4 * i), 32'(duty[i]));
      wr(5'h14, {28'd0, ctl});
      wr(5'h10, 32'(p));
      tick(2 * p + 6);
      measure(p);
      for (int i = 0; i < 4; i++)
        chk($sformatf("rnd%0d_ch%0d", r, i), hi_cnt[i],
            ctl[i] ? 32'((duty[i] < p) ? duty[i] : p) : 32'd0);
      rd(5'h18, d0);
      chk($sformatf("rnd%0d_cnt_range", r), {31'd0, d0 < 32'(p)}, 32'd1);
    end

    // Back-pressure on both response channels
    wr_req(5'h04, 32'hAAAA_5555, 4'hF);
    bus.awaddr = 5'h04; bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    held = 1'b1; acc = 1'b0;
    repeat (5) begin
      tick();
      held &= bus.bvalid;
      acc  |= bus.awready;
    end
    chk("bvalid_hold", {31'd0, held}, 32'd1);
    chk("wr_blocked", {31'd0, acc}, 32'd0);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = bus.awready;
    end
    chk("wr2_accept", {31'd0, ok}, 32'd1);
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    wr_rsp();
    rd_req(5'h04);
    d0 = bus.rdata; held = 1'b1; stable = 1'b1;
    repeat (5) begin
      tick();
      held   &= bus.rvalid;
      stable &= (bus.rdata === d0);
    end
    chk("rvalid_hold", {31'd0, held}, 32'd1);
    chk("rdata_stable", {31'd0, stable}, 32'd1);
    chk("wr2_data", d0, 32'h1234_5678);
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;

    // Asynchronous reset while a write response is pending
    wr(5'h10, 32'd10);
    wr(5'h14, 32'hF);
    tick(25);
    wr_req(5'h08, 32'h0000_0055, 4'hF);
    #2;
    tb_ARESETN = 1'b0;
    #1;
    chk("arst_bvalid", {31'd0, bus.bvalid}, 32'd0);
    chk("arst_pwm", {28'd0, pwm_out}, 32'd0);
    tick(2);
    tb_ARESETN = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      tick();
      bad |= bus.bvalid | bus.rvalid | (|pwm_out);
    end
    chk("arst_quiet", {31'd0, bad}, 32'd0);
    rd_chk(5'h10, 32'd0, "arst_period");
    rd_chk(5'h14, 32'd0, "arst_ctrl");
    rd_chk(5'h08, 32'd0, "arst_duty2");
    rd_chk(5'h18, 32'd0, "arst_count");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
